// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC field-edit controller: FSM states, field
// indices and default timing constants.
package rtc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   localparam int FLD_SEG  = 0;
   localparam int FLD_MIN  = 1;
   localparam int FLD_HORA = 2;
   localparam int FLD_DIA  = 3;
   localparam int FLD_MES  = 4;
   localparam int FLD_ANIO = 5;

   localparam int HOLDOFF_CYCLES_DEF = 1048576;
   localparam int TIMEOUT_CYCLES_DEF = 33554432;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one synchronised button level. A button already
// held when reset releases stays silent until it has been seen low once.
module btn_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_rise
);

   logic r_prev;
   logic r_armed;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_prev  <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_prev  <= i_btn;
         r_armed <= r_armed | ~i_btn;
      end
   end

   assign o_rise = i_btn & ~r_prev & r_armed;

endmodule

// File: rtl/rtc_edit_ctrl.sv
// Edit-mode sequencer for the RTC BCD field registers: field selection,
// UP/DOWN pulses with hold-off, RTC load gating and write-back request.
// Optional build macro EDIT_TIMEOUT_EN adds an edit-inactivity timeout.
module rtc_edit_ctrl
   import rtc_pkg::*;
#(
   parameter  int NUM_FIELDS     = 6,
   parameter  int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
   parameter  int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   localparam int IW             = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  BTN_EDIT,
   input  logic                  BTN_NEXT,
   input  logic                  BTN_UP,
   input  logic                  BTN_DOWN,
   input  logic                  RTC_READ_DONE,
   input  logic                  WRITE_ACK,
   output logic [NUM_FIELDS-1:0] MOD_SEL,
   output logic                  UP_PULSE,
   output logic                  DOWN_PULSE,
   output logic                  ACTUALIZAR,
   output logic                  WRITE_REQ,
   output logic [IW-1:0]         FIELD_IDX,
   output logic                  EDITING
);

   localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

   if (HOLDOFF_CYCLES < 1 || TIMEOUT_CYCLES < 1 || NUM_FIELDS < 2) begin : g_bad_param
      $error("rtc_edit_ctrl: invalid parameter value");
   end

   logic w_edit_e;
   logic w_next_e;
   logic w_up_e;
   logic w_down_e;

   btn_edge u_edge_edit (.i_clk(CLK), .i_rst(RESET), .i_btn(BTN_EDIT), .o_rise(w_edit_e));
   btn_edge u_edge_next (.i_clk(CLK), .i_rst(RESET), .i_btn(BTN_NEXT), .o_rise(w_next_e));
   btn_edge u_edge_up   (.i_clk(CLK), .i_rst(RESET), .i_btn(BTN_UP),   .o_rise(w_up_e));
   btn_edge u_edge_down (.i_clk(CLK), .i_rst(RESET), .i_btn(BTN_DOWN), .o_rise(w_down_e));

   state_t                r_state;
   logic [HW-1:0]         r_hold;
   logic [IW-1:0]         r_idx;
   logic [NUM_FIELDS-1:0] r_mod_sel;
   logic                  r_up;
   logic                  r_down;
   logic                  r_act;
   logic                  r_wreq;
   logic                  r_editing;

   function automatic logic [NUM_FIELDS-1:0] onehot(input logic [IW-1:0] idx);
      return NUM_FIELDS'(1) << idx;
   endfunction

   logic          w_hold_idle;
   logic          w_up_ok;
   logic          w_down_ok;
   logic [IW-1:0] w_idx_inc;

   // Simultaneous UP and DOWN levels cancel each other out.
   assign w_hold_idle = (r_hold == '0);
   assign w_up_ok     = w_up_e   & ~BTN_DOWN & w_hold_idle;
   assign w_down_ok   = w_down_e & ~BTN_UP   & w_hold_idle;
   assign w_idx_inc   = (r_idx == IW'(NUM_FIELDS - 1)) ? '0 : r_idx + 1'b1;

`ifdef EDIT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_to;
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state   <= ST_IDLE;
         r_hold    <= '0;
         r_idx     <= '0;
         r_mod_sel <= '0;
         r_up      <= 1'b0;
         r_down    <= 1'b0;
         r_act     <= 1'b0;
         r_wreq    <= 1'b0;
         r_editing <= 1'b0;
`ifdef EDIT_TIMEOUT_EN
         r_to      <= '0;
`endif
      end else begin
         r_up   <= 1'b0;
         r_down <= 1'b0;
         r_act  <= 1'b0;
         if (!w_hold_idle) begin
            r_hold <= r_hold - 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_edit_e) begin
                  r_state   <= ST_EDIT;
                  r_idx     <= IW'(FLD_SEG);
                  r_mod_sel <= onehot(IW'(FLD_SEG));
                  r_editing <= 1'b1;
`ifdef EDIT_TIMEOUT_EN
                  r_to      <= '0;
`endif
               end else begin
                  r_act <= RTC_READ_DONE;
               end
            end

            // Edge priority EDIT > NEXT > UP/DOWN; losers in the same cycle are dropped.
            ST_EDIT: begin
               if (w_edit_e) begin
                  r_state   <= ST_COMMIT;
                  r_mod_sel <= '0;
                  r_editing <= 1'b0;
                  r_wreq    <= 1'b1;
               end else if (w_next_e) begin
                  r_idx     <= w_idx_inc;
                  r_mod_sel <= onehot(w_idx_inc);
`ifdef EDIT_TIMEOUT_EN
                  r_to      <= '0;
`endif
               end else if (w_up_ok) begin
                  r_up   <= 1'b1;
                  r_hold <= HW'(HOLDOFF_CYCLES - 1);
`ifdef EDIT_TIMEOUT_EN
                  r_to   <= '0;
`endif
               end else if (w_down_ok) begin
                  r_down <= 1'b1;
                  r_hold <= HW'(HOLDOFF_CYCLES - 1);
`ifdef EDIT_TIMEOUT_EN
                  r_to   <= '0;
`endif
               end
`ifdef EDIT_TIMEOUT_EN
               // Inactivity abandons the edit; the next RTC read refreshes the fields.
               else if (r_to == TW'(TIMEOUT_CYCLES - 1)) begin
                  r_state   <= ST_IDLE;
                  r_mod_sel <= '0;
                  r_editing <= 1'b0;
                  r_to      <= '0;
               end else begin
                  r_to <= r_to + 1'b1;
               end
`endif
            end

            ST_COMMIT: begin
               if (WRITE_ACK) begin
                  r_state <= ST_IDLE;
                  r_wreq  <= 1'b0;
               end
            end

            default: begin
               r_state   <= ST_IDLE;
               r_mod_sel <= '0;
               r_editing <= 1'b0;
               r_wreq    <= 1'b0;
            end
         endcase
      end
   end

   assign MOD_SEL    = r_mod_sel;
   assign UP_PULSE   = r_up;
   assign DOWN_PULSE = r_down;
   assign ACTUALIZAR = r_act;
   assign WRITE_REQ  = r_wreq;
   assign FIELD_IDX  = r_idx;
   assign EDITING    = r_editing;

endmodule

// File: tb/tb_rtc_edit_ctrl.sv
// Directed bench for rtc_edit_ctrl with short hold-off and timeout values.
module tb_rtc_edit_ctrl;

   localparam int NF = 6;
   localparam int IW = 3;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          BTN_EDIT = 1'b0;
   logic          BTN_NEXT = 1'b0;
   logic          BTN_UP = 1'b0;
   logic          BTN_DOWN = 1'b0;
   logic          RTC_READ_DONE = 1'b0;
   logic          WRITE_ACK = 1'b0;
   logic [NF-1:0] MOD_SEL;
   logic          UP_PULSE;
   logic          DOWN_PULSE;
   logic          ACTUALIZAR;
   logic          WRITE_REQ;
   logic [IW-1:0] FIELD_IDX;
   logic          EDITING;

   int n_cmp = 0;
   int n_err = 0;

   rtc_edit_ctrl #(
      .NUM_FIELDS    (NF),
      .HOLDOFF_CYCLES(8),
      .TIMEOUT_CYCLES(20)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .BTN_EDIT     (BTN_EDIT),
      .BTN_NEXT     (BTN_NEXT),
      .BTN_UP       (BTN_UP),
      .BTN_DOWN     (BTN_DOWN),
      .RTC_READ_DONE(RTC_READ_DONE),
      .WRITE_ACK    (WRITE_ACK),
      .MOD_SEL      (MOD_SEL),
      .UP_PULSE     (UP_PULSE),
      .DOWN_PULSE   (DOWN_PULSE),
      .ACTUALIZAR   (ACTUALIZAR),
      .WRITE_REQ    (WRITE_REQ),
      .FIELD_IDX    (FIELD_IDX),
      .EDITING      (EDITING)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic press_next();
      BTN_NEXT = 1'b1;
      tick();
      BTN_NEXT = 1'b0;
      tick();
   endtask

   int cnt;
   int seen_wreq;

   initial begin
      tick(2);
      check("rst_mod_sel", 32'(MOD_SEL), 32'h0);
      check("rst_editing", 32'(EDITING), 32'h0);
      check("rst_wreq",    32'(WRITE_REQ), 32'h0);
      check("rst_idx",     32'(FIELD_IDX), 32'h0);
      RESET = 1'b0;
      tick(3);

      // IDLE: RTC load passes through one cycle late, UP is ignored
      RTC_READ_DONE = 1'b1;
      tick();
      RTC_READ_DONE = 1'b0;
      check("idle_act_hi", 32'(ACTUALIZAR), 32'h1);
      check("idle_mod_sel", 32'(MOD_SEL), 32'h0);
      tick();
      check("idle_act_lo", 32'(ACTUALIZAR), 32'h0);
      BTN_UP = 1'b1;
      tick();
      BTN_UP = 1'b0;
      check("idle_up_ignored", 32'(UP_PULSE), 32'h0);
      tick();

      // Enter EDIT and walk the fields
      BTN_EDIT = 1'b1;
      tick();
      BTN_EDIT = 1'b0;
      check("edit_enter", 32'(EDITING), 32'h1);
      check("edit_idx0", 32'(FIELD_IDX), 32'h0);
      check("edit_mod0", 32'(MOD_SEL), 32'b000001);
      tick();
      for (int i = 0; i < 4; i++) press_next();
      check("next4_idx", 32'(FIELD_IDX), 32'h4);
      check("next4_mod", 32'(MOD_SEL), 32'b010000);
      press_next();
      press_next();
      check("wrap_idx", 32'(FIELD_IDX), 32'h0);
      check("wrap_mod", 32'(MOD_SEL), 32'b000001);

      // Hold-off: edges at 0 and 3 give one pulse, edge at 9 gives another
      BTN_UP = 1'b1;
      tick();
      BTN_UP = 1'b0;
      check("ho_pulse1", 32'(UP_PULSE), 32'h1);
      tick();
      check("ho_pulse1_len", 32'(UP_PULSE), 32'h0);
      tick();
      BTN_UP = 1'b1;
      tick();
      BTN_UP = 1'b0;
      check("ho_blocked", 32'(UP_PULSE), 32'h0);
      tick(5);
      BTN_UP = 1'b1;
      tick();
      BTN_UP = 1'b0;
      check("ho_pulse2", 32'(UP_PULSE), 32'h1);
      tick();
      check("ho_pulse2_len", 32'(UP_PULSE), 32'h0);
      tick(10);

      BTN_UP = 1'b1;
      BTN_DOWN = 1'b1;
      tick();
      check("both_up", 32'(UP_PULSE), 32'h0);
      check("both_down", 32'(DOWN_PULSE), 32'h0);
      BTN_UP = 1'b0;
      BTN_DOWN = 1'b0;
      tick(2);
      BTN_DOWN = 1'b1;
      tick();
      BTN_DOWN = 1'b0;
      check("down_pulse", 32'(DOWN_PULSE), 32'h1);
      tick();
      check("down_pulse_len", 32'(DOWN_PULSE), 32'h0);
      tick(10);

      // NEXT beats UP in the same cycle
      BTN_NEXT = 1'b1;
      BTN_UP = 1'b1;
      tick();
      BTN_NEXT = 1'b0;
      BTN_UP = 1'b0;
      check("prio_idx", 32'(FIELD_IDX), 32'h1);
      check("prio_mod", 32'(MOD_SEL), 32'b000010);
      check("prio_no_up", 32'(UP_PULSE), 32'h0);
      tick();
      RTC_READ_DONE = 1'b1;
      tick();
      RTC_READ_DONE = 1'b0;
      check("edit_act_blocked", 32'(ACTUALIZAR), 32'h0);
      tick();
      check("edit_act_blocked2", 32'(ACTUALIZAR), 32'h0);

      // COMMIT with acknowledge after five cycles
      BTN_EDIT = 1'b1;
      tick();
      BTN_EDIT = 1'b0;
      check("commit_editing", 32'(EDITING), 32'h0);
      check("commit_mod", 32'(MOD_SEL), 32'h0);
      cnt = WRITE_REQ ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (WRITE_REQ) cnt++;
      end
      WRITE_ACK = 1'b1;
      tick();
      WRITE_ACK = 1'b0;
      check("commit_wreq_cycles", 32'(cnt), 32'd5);
      check("commit_wreq_drop", 32'(WRITE_REQ), 32'h0);
      check("commit_idx_kept", 32'(FIELD_IDX), 32'h1);
      tick();
      check("commit_idle_act", 32'(ACTUALIZAR), 32'h0);
      RTC_READ_DONE = 1'b1;
      tick();
      RTC_READ_DONE = 1'b0;
      check("post_commit_act", 32'(ACTUALIZAR), 32'h1);

      // Re-entry restarts at field 0, then reset lands mid-COMMIT
      BTN_EDIT = 1'b1;
      tick();
      BTN_EDIT = 1'b0;
      check("reenter_idx", 32'(FIELD_IDX), 32'h0);
      tick();
      BTN_EDIT = 1'b1;
      tick();
      check("commit2_wreq", 32'(WRITE_REQ), 32'h1);
      #2;
      RESET = 1'b1;
      #1;
      check("async_rst_wreq", 32'(WRITE_REQ), 32'h0);
      check("async_rst_editing", 32'(EDITING), 32'h0);
      tick(2);
      RESET = 1'b0;
      tick(3);
      check("held_btn_no_edge", 32'(EDITING), 32'h0);
      BTN_EDIT = 1'b0;
      tick();
      BTN_EDIT = 1'b1;
      tick();
      BTN_EDIT = 1'b0;
      check("repress_edit", 32'(EDITING), 32'h1);
      tick();

      // Single-cycle COMMIT
      BTN_EDIT = 1'b1;
      tick();
      BTN_EDIT = 1'b0;
      WRITE_ACK = 1'b1;
      check("fast_commit_req", 32'(WRITE_REQ), 32'h1);
      tick();
      WRITE_ACK = 1'b0;
      check("fast_commit_done", 32'(WRITE_REQ), 32'h0);
      tick();

      BTN_EDIT = 1'b1;
      tick();
      BTN_EDIT = 1'b0;
      check("to_enter", 32'(EDITING), 32'h1);
      seen_wreq = 0;
      cnt = 1;
`ifdef EDIT_TIMEOUT_EN
      for (int i = 0; i < 40; i++) begin
         tick();
         if (WRITE_REQ) seen_wreq = 1;
         if (!EDITING) break;
         cnt++;
      end
      check("to_exit", 32'(EDITING), 32'h0);
      check("to_cycles", 32'(cnt), 32'd20);
      check("to_no_wreq", 32'(seen_wreq), 32'h0);
`else
      for (int i = 0; i < 40; i++) begin
         tick();
         if (WRITE_REQ) seen_wreq = 1;
         if (EDITING) cnt++;
      end
      check("no_to_editing", 32'(cnt), 32'd41);
      check("no_to_wreq", 32'(seen_wreq), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rtc_edit_ctrl.md
Name: rtc_edit_ctrl

Overview:
Central controller that sequences the per-field RTC BCD registers (seconds, minutes, hours, day, month, year). It decides which register is in manual modification and turns raw button levels into single-cycle UP/DOWN pulses with hold-off. It also gates the "update from RTC" strobe so it never fires during editing, and requests a write-back to the RTC when editing ends. It sits between the button synchroniser and the bank of field registers / RTC write engine.

Parameters:
NUM_FIELDS, 6, number of editable field registers; field index 0..NUM_FIELDS-1.
HOLDOFF_CYCLES, 1048576, CLK cycles during which further UP/DOWN edges are ignored after an accepted pulse.
TIMEOUT_CYCLES, 33554432, edit-inactivity limit in CLK cycles; used only with EDIT_TIMEOUT_EN.

Ports:
CLK  in  1  system clock, all logic on rising edge.
RESET  in  1  asynchronous, active-high reset.
BTN_EDIT  in  1  synchronised level; rising edge enters/leaves edit mode.
BTN_NEXT  in  1  synchronised level; rising edge selects next field.
BTN_UP  in  1  synchronised level; increment request.
BTN_DOWN  in  1  synchronised level; decrement request.
RTC_READ_DONE  in  1  one-cycle pulse, fresh RTC data valid on the field registers' DATA_in.
WRITE_ACK  in  1  RTC write engine has accepted the write-back.
MOD_SEL  out  NUM_FIELDS  one-hot Modificando per field register; all zero outside EDIT.
UP_PULSE  out  1  one-cycle increment strobe, shared by all field registers.
DOWN_PULSE  out  1  one-cycle decrement strobe, shared.
ACTUALIZAR  out  1  one-cycle load-from-RTC strobe, shared.
WRITE_REQ  out  1  write-back request, held until acknowledged.
FIELD_IDX  out  $clog2(NUM_FIELDS)  current field index, for display blinking.
EDITING  out  1  high in EDIT state.

Behaviour:
- Reset (async, any time, including mid-COMMIT): state IDLE, FIELD_IDX 0, hold-off counter 0, edge-detect history 0, all outputs 0. Any pending WRITE_REQ is abandoned.
- Edge detection: each BTN_* is registered once; an edge is current=1 and previous=0. A button held across reset produces no edge until it is released and pressed again.
- All outputs are registered; decisions take effect 1 cycle after the edge.
- IDLE:
  - ACTUALIZAR = RTC_READ_DONE delayed 1 cycle.
  - MOD_SEL = 0; UP/DOWN edges are ignored.
  - EDIT edge -> EDIT, with FIELD_IDX = 0.
- EDIT:
  - MOD_SEL = one-hot(FIELD_IDX); ACTUALIZAR forced 0; RTC_READ_DONE is dropped.
  - UP edge with BTN_DOWN=0 and hold-off idle -> UP_PULSE for exactly 1 cycle; hold-off counter loads HOLDOFF_CYCLES-1 and counts to 0.
  - DOWN is symmetric to UP.
  - Edges arriving while hold-off is non-zero are discarded, not queued.
  - UP and DOWN both high -> no pulse.
  - NEXT edge -> FIELD_IDX = FIELD_IDX+1, wrapping NUM_FIELDS-1 -> 0; hold-off is not cleared.
- Priority in EDIT when edges coincide: EDIT > NEXT > UP/DOWN. The lower-priority edges in that cycle are dropped, so a pulse never lands on a changing MOD_SEL.
- EDIT edge in EDIT -> COMMIT. MOD_SEL clears the same cycle the state changes.
- COMMIT:
  - WRITE_REQ = 1; MOD_SEL = 0; ACTUALIZAR = 0; all buttons ignored.
  - WRITE_ACK sampled high -> IDLE; WRITE_REQ is 0 from the next cycle.
  - WRITE_ACK high on the first COMMIT cycle is legal (single-cycle COMMIT).
- FIELD_IDX keeps its value across IDLE/COMMIT; it resets to 0 on each entry to EDIT.
- Hold-off counter width is $clog2(HOLDOFF_CYCLES); it never wraps.

Optional Feature:
EDIT_TIMEOUT_EN
- Defined: an inactivity counter runs in EDIT and reloads on any accepted edge (EDIT/NEXT/UP/DOWN). Reaching TIMEOUT_CYCLES -> IDLE without COMMIT: edits are discarded, and the next RTC_READ_DONE reloads the registers.
- Undefined: no counter; EDIT persists until an EDIT edge.

Decomposition:
- Package rtc_pkg holds:
  - state encoding (ST_IDLE, ST_EDIT, ST_COMMIT);
  - field index constants (FLD_SEG=0, FLD_MIN=1, FLD_HORA=2, FLD_DIA=3, FLD_MES=4, FLD_ANIO=5);
  - default HOLDOFF_CYCLES and TIMEOUT_CYCLES.
- One sub-module, btn_edge, holds the 1-bit register plus rising-edge output. It is instantiated four times; hold-off stays in the top level.

Test Plan:
- Reset, then RTC_READ_DONE pulse at cycle 10 -> ACTUALIZAR high at cycle 11 only; MOD_SEL=000000.
- EDIT press, then NEXT x4 -> FIELD_IDX=4, MOD_SEL=010000; NEXT x2 more -> wraps to 0, MOD_SEL=000001.
- HOLDOFF_CYCLES=8, UP edges at cycles 0 and 3 -> one UP_PULSE at cycle 1; UP edge at cycle 9 -> second pulse at cycle 10. UP+DOWN both high -> no pulse.
- NEXT and UP edges in the same cycle -> FIELD_IDX increments, no UP_PULSE. RTC_READ_DONE during EDIT -> ACTUALIZAR stays 0.
- EDIT press in EDIT, WRITE_ACK after 5 cycles -> WRITE_REQ high 5 cycles then 0; state IDLE. Assert RESET mid-COMMIT -> WRITE_REQ 0 immediately (async).
- With EDIT_TIMEOUT_EN and TIMEOUT_CYCLES=20 -> no activity for 20 cycles in EDIT gives EDITING=0, WRITE_REQ never asserted.
